led_scan_controller: RTL and testbench



---
 rtl/led_scan_controller.sv | 117 +++++++++++
 tb/tb_led_scan_controller.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/led_scan_controller.sv
// Scan controller: multiplexes an active digit file onto one shared hex decoder, with a dead-time GAP between slots.
// Latency: outputs are registered, and a commit becomes visible in the first slot-0 cycle after the frame_tick GAP.
// Backpressure: wr_ready drops only in the commit cycle. Define LED_SCAN_LZB_EN to enable leading-zero blanking.
module led_scan_controller #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [$clog2(DIGITS)-1:0] wr_index,
    input  logic [3:0]                wr_value,
    input  logic                      update_req,
    output logic                      update_pending,
    output logic [3:0]                hex,
    output logic [DIGITS-1:0]         digit_sel,
    output logic                      blank,
    output logic                      frame_tick
);
    localparam int IW = $clog2(DIGITS);
    localparam int PW = $clog2(SCAN_DIV);

    typedef enum logic {SCAN, GAP} state_t;

    state_t        state;
    logic [IW-1:0] slot;
    logic [PW-1:0] presc;
    logic [3:0]    shadow    [DIGITS];
    logic [3:0]    active    [DIGITS];
    logic [3:0]    active_nx [DIGITS];
    logic          commit;
    logic          scan_blank;

    // frame_tick is high for exactly the frame-end GAP cycle, so this marks the commit cycle
    assign commit   = frame_tick && update_pending;
    assign wr_ready = !commit;

    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            active_nx[i] = commit ? shadow[i] : active[i];
        end
    end

`ifdef LED_SCAN_LZB_EN
    logic [DIGITS-1:0] lz;
    logic              zero_run;

    always_comb begin
        lz       = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (active_nx[i] == 4'd0);
            lz[i]    = zero_run;
        end
        lz[0] = 1'b0;
    end

    assign scan_blank = lz[slot];
`else
    assign scan_blank = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= SCAN;
            slot           <= '0;
            presc          <= '0;
            update_pending <= 1'b0;
            digit_sel      <= '0;
            hex            <= 4'd0;
            blank          <= 1'b1;
            frame_tick     <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                shadow[i] <= 4'd0;
                active[i] <= 4'd0;
            end
        end else begin
            if (wr_valid && wr_ready && (int'(wr_index) < DIGITS)) begin
                shadow[wr_index] <= wr_value;
            end
            for (int i = 0; i < DIGITS; i++) begin
                active[i] <= active_nx[i];
            end

            // A request landing on the commit cycle re-arms for the next frame
            if (update_req) begin
                update_pending <= 1'b1;
            end else if (commit) begin
                update_pending <= 1'b0;
            end

            frame_tick <= 1'b0;
            case (state)
                SCAN: begin
                    digit_sel <= DIGITS'(1) << slot;
                    hex       <= active_nx[slot];
                    blank     <= scan_blank;
                    if (presc == PW'(SCAN_DIV - 1)) begin
                        presc <= '0;
                        state <= GAP;
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end
                GAP: begin
                    digit_sel  <= '0;
                    blank      <= 1'b1;
                    frame_tick <= (slot == IW'(DIGITS - 1));
                    slot       <= (slot == IW'(DIGITS - 1)) ? '0 : slot + IW'(1);
                    state      <= SCAN;
                end
                default: state <= SCAN;
            endcase
        end
    end
endmodule

// File: tb/tb_led_scan_controller.sv
// Directed bench for led_scan_controller with DIGITS=4, SCAN_DIV=4 (20-cycle frames).
module tb_led_scan_controller;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [1:0] wr_index = 2'd0;
    logic [3:0] wr_value = 4'd0;
    logic       update_req = 1'b0;
    logic       update_pending;
    logic [3:0] hex;
    logic [3:0] digit_sel;
    logic       blank;
    logic       frame_tick;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    logic [3:0] exp_act [4];

    led_scan_controller #(.DIGITS(4), .SCAN_DIV(4)) dut (
        .clk(clk),
        .rst(rst),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_index(wr_index),
        .wr_value(wr_value),
        .update_req(update_req),
        .update_pending(update_pending),
        .hex(hex),
        .digit_sel(digit_sel),
        .blank(blank),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_digit_sel"}, 32'(digit_sel), 32'd0);
        chk({tag, "_hex"}, 32'(hex), 32'd0);
        chk({tag, "_blank"}, 32'(blank), 32'd1);
        chk({tag, "_frame_tick"}, 32'(frame_tick), 32'd0);
        chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
        chk({tag, "_pending"}, 32'(update_pending), 32'd0);
    endtask

    // Advance n cycles; at each falling edge compare the scan outputs with the frame position.
    task automatic run_check(input int n);
        int   c, s, r;
        logic eb;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            c = (cyc - 1) % 20;
            s = c / 5;
            r = c % 5;
            if (r < 4) begin
`ifdef LED_SCAN_LZB_EN
                eb = (s > 0);
                for (int j = s; j < 4; j++) if (exp_act[j] != 4'd0) eb = 1'b0;
`else
                eb = 1'b0;
`endif
                chk($sformatf("digit_sel@%0d", cyc), 32'(digit_sel), 32'(4'b0001 << s));
                chk($sformatf("hex@%0d", cyc), 32'(hex), 32'(exp_act[s]));
                chk($sformatf("blank@%0d", cyc), 32'(blank), 32'(eb));
                chk($sformatf("frame_tick@%0d", cyc), 32'(frame_tick), 32'd0);
            end else begin
                chk($sformatf("gap_digit_sel@%0d", cyc), 32'(digit_sel), 32'd0);
                chk($sformatf("gap_blank@%0d", cyc), 32'(blank), 32'd1);
                chk($sformatf("gap_frame_tick@%0d", cyc), 32'(frame_tick), 32'(s == 3));
            end
        end
    endtask

    task automatic write(input int idx, input int val);
        wr_valid = 1'b1;
        wr_index = idx[1:0];
        wr_value = val[3:0];
        run_check(1);
        wr_valid = 1'b0;
    endtask

    task automatic pulse_req();
        update_req = 1'b1;
        run_check(1);
        update_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) exp_act[i] = 4'd0;
        repeat (3) @(negedge clk);
        chk_reset_state("por");
        rst = 1'b0;
        cyc = 0;

        // Idle scan with all-zero digits
        run_check(20);

        // Load 1,2,3,4 and request a commit at the frame boundary (cycle 40)
        write(0, 1);
        write(1, 2);
        write(2, 3);
        write(3, 4);
        pulse_req();
        chk("pending_set", 32'(update_pending), 32'd1);
        chk("ready_idle", 32'(wr_ready), 32'd1);
        run_check(15);
        chk("commit1_ready", 32'(wr_ready), 32'd0);
        chk("commit1_pending", 32'(update_pending), 32'd1);
        exp_act[0] = 4'd1;
        exp_act[1] = 4'd2;
        exp_act[2] = 4'd3;
        exp_act[3] = 4'd4;
        run_check(1);
        chk("pending_cleared", 32'(update_pending), 32'd0);
        run_check(19);

        // Shadow-only write stays hidden for three frames
        write(2, 7);
        run_check(59);
        pulse_req();
        chk("pending_set2", 32'(update_pending), 32'd1);
        run_check(19);
        chk("commit2_ready", 32'(wr_ready), 32'd0);
        exp_act[2] = 4'd7;
        run_check(5);

        // A write held across the commit cycle is stalled and lands after it
        pulse_req();
        run_check(14);
        chk("commit3_frame_tick", 32'(frame_tick), 32'd1);
        wr_valid = 1'b1;
        wr_index = 2'd0;
        wr_value = 4'd9;
        #1;
        chk("commit3_ready_stall", 32'(wr_ready), 32'd0);
        run_check(1);
        chk("post_commit3_ready", 32'(wr_ready), 32'd1);
        chk("post_commit3_pending", 32'(update_pending), 32'd0);
        run_check(1);
        wr_valid = 1'b0;
        run_check(8);
        pulse_req();
        run_check(9);
        chk("commit4_ready", 32'(wr_ready), 32'd0);

        // update_req coinciding with a commit keeps pending for the next frame
        exp_act[0] = 4'd9;
        update_req = 1'b1;
        run_check(1);
        update_req = 1'b0;
        chk("req_on_commit_pending", 32'(update_pending), 32'd1);
        run_check(19);
        chk("pending_held", 32'(update_pending), 32'd1);
        run_check(1);
        chk("pending_cleared2", 32'(update_pending), 32'd0);

        // Reset in the middle of slot 2 with a commit outstanding
        run_check(1);
        pulse_req();
        run_check(9);
        chk("pre_rst_pending", 32'(update_pending), 32'd1);
        chk("pre_rst_slot2", 32'(digit_sel), 32'd4);
        rst = 1'b1;
        #1;
        chk_reset_state("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        for (int i = 0; i < 4; i++) exp_act[i] = 4'd0;
        run_check(1);
        pulse_req();
        run_check(18);
        chk("post_rst_commit_ready", 32'(wr_ready), 32'd0);
        run_check(20);

        // Single non-zero digit in slot 1: exercises leading-zero blanking when enabled
        write(1, 5);
        pulse_req();
        run_check(18);
        exp_act[1] = 4'd5;
        run_check(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
